// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle for the serial_adder block.
//   master: drives start, a, b, cin (and sub when SERIAL_ADDER_SUB_EN is defined),
//           observes busy, done, sum, cout.
//   slave : the adder itself, the mirror image of master.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub (subtract select) signal.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start,
      output a,
      output b,
      output cin,
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      input  busy,
      input  done,
      input  sum,
      input  cout
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  cin,
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      output busy,
      output done,
      output sum,
      output cout
   );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that adds two WIDTH-bit operands DIGIT bits
// per clock, least-significant digit first, through a registered carry.
// A result takes N = WIDTH/DIGIT busy cycles plus one done cycle.
//
// Parameters:
//   WIDTH  operand/sum width (>= 1)
//   DIGIT  bits added per cycle, must divide WIDTH exactly
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, priority over everything
//   bus   serial_adder_if.slave:
//           start (in)  request, accepted while busy=0
//           a, b  (in)  operands, sampled on the accepting edge
//           cin   (in)  carry-in, sampled on the accepting edge
//           sub   (in)  subtract select (only with SERIAL_ADDER_SUB_EN)
//           busy  (out) digit cycles in progress
//           done  (out) one-cycle result-valid pulse
//           sum   (out) result, held until the next completion
//           cout  (out) carry out of the MSB, held with sum
// Optional feature macro: SERIAL_ADDER_SUB_EN (a - b via inverted B and forced carry-in).
module serial_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);

   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Operand, partial-result and carry shift registers
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   // Registered outputs
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;

   // Next-state side information
   logic             accept;
   logic             last_digit;

   // Operand conditioning at the accepting edge
   logic [WIDTH-1:0] b_in;
   logic             c_in;

   // One digit of addition: {carry_out, digit_sum}
   logic [DIGIT:0]   digit_add;
   logic [WIDTH-1:0] res_shift;

   // Subtraction reuses the adder: a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
   always_comb begin
      b_in = bus.b;
      c_in = bus.cin;
      if (bus.sub) begin
         b_in = ~bus.b;
         c_in = 1'b1;
      end
   end
`else
   always_comb begin
      b_in = bus.b;
      c_in = bus.cin;
   end
`endif

   // Digit adder and result shift: new digit enters at the MSB end
   always_comb begin
      digit_add = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                + (DIGIT+1)'(carry);
      res_shift = WIDTH'({digit_add[DIGIT-1:0], res_sr} >> DIGIT);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      last_digit = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == CNT_W'(N - 1)) begin
               last_digit = 1'b1;
               state_nxt  = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_nxt == BUSY);
         done_q <= (state_nxt == DONE);
         if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= b_in;
            carry  <= c_in;
            res_sr <= '0;
            cnt    <= '0;
         end else if (state == BUSY) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            carry  <= digit_add[DIGIT];
            res_sr <= res_shift;
            cnt    <= cnt + CNT_W'(1);
            // sum/cout only move on the edge that enters DONE
            if (last_digit) begin
               sum_q  <= res_shift;
               cout_q <= digit_add[DIGIT];
            end
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks serial_adder at WIDTH=8 with DIGIT = 1, 2, 4 and 8
// (N = 8, 4, 2, 1) against an arithmetic reference model.
module tb_serial_adder;

   localparam int unsigned NDUT = 4;

   logic       clk;
   logic       rst;
   logic       start_d [NDUT];
   logic [7:0] a_d     [NDUT];
   logic [7:0] b_d     [NDUT];
   logic       cin_d   [NDUT];
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub_d   [NDUT];
`endif
   logic       busy_o  [NDUT];
   logic       done_o  [NDUT];
   logic [7:0] sum_o   [NDUT];
   logic       cout_o  [NDUT];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // One DUT per digit size: instance g uses DIGIT = 2**g
   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned DG = 1 << g;
      serial_adder_if #(.WIDTH(8)) bus ();
      assign bus.start = start_d[g];
      assign bus.a     = a_d[g];
      assign bus.b     = b_d[g];
      assign bus.cin   = cin_d[g];
`ifdef SERIAL_ADDER_SUB_EN
      assign bus.sub   = sub_d[g];
`endif
      assign busy_o[g] = bus.busy;
      assign done_o[g] = bus.done;
      assign sum_o[g]  = bus.sum;
      assign cout_o[g] = bus.cout;
      serial_adder #(.WIDTH(8), .DIGIT(DG)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   function automatic int n_of(input int sel);
      return 8 / (1 << sel);
   endfunction

   // Reference: plain 9-bit arithmetic; subtract gives a-b with cout = no borrow
   function automatic logic [8:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic ci, input logic sb);
      int s;
      if (sb) begin
         s = (int'(a) - int'(b)) & 255;
         return {(a >= b), 8'(s)};
      end
      s = int'(a) + int'(b) + int'(ci);
      return 9'(s);
   endfunction

   // Full transaction with exact cycle timing and result check
   task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb, input string tag);
      int         n;
      logic [8:0] exp9;
      logic [7:0] prev_sum;
      logic       prev_cout;
      n         = n_of(sel);
      exp9      = ref_model(a, b, ci, sb);
      prev_sum  = sum_o[sel];
      prev_cout = cout_o[sel];
      @(negedge clk);
      start_d[sel] = 1'b1;
      a_d[sel]     = a;
      b_d[sel]     = b;
      cin_d[sel]   = ci;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d[sel]   = sb;
`endif
      @(posedge clk);
      #1;
      start_d[sel] = 1'b0;
      a_d[sel]     = 8'($urandom);
      b_d[sel]     = 8'($urandom);
      cin_d[sel]   = 1'($urandom);
      for (int i = 0; i < n; i++) begin
         checks++;
         if (busy_o[sel] !== 1'b1 || done_o[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_phase sel=%0d cyc=%0d: busy=%b done=%b, required busy=1 done=0",
                     tag, sel, i, busy_o[sel], done_o[sel]);
         end
         checks++;
         if (sum_o[sel] !== prev_sum || cout_o[sel] !== prev_cout) begin
            errors++;
            $display("FAIL %s sum_stable sel=%0d cyc=%0d: sum=%h cout=%b, required sum=%h cout=%b",
                     tag, sel, i, sum_o[sel], cout_o[sel], prev_sum, prev_cout);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (done_o[sel] !== 1'b1 || busy_o[sel] !== 1'b0) begin
         errors++;
         $display("FAIL %s done_pulse sel=%0d: done=%b busy=%b, required done=1 busy=0",
                  tag, sel, done_o[sel], busy_o[sel]);
      end
      checks++;
      if ({cout_o[sel], sum_o[sel]} !== exp9) begin
         errors++;
         $display("FAIL %s result sel=%0d a=%h b=%h cin=%b sub=%b: cout=%b sum=%h, required cout=%b sum=%h",
                  tag, sel, a, b, ci, sb, cout_o[sel], sum_o[sel], exp9[8], exp9[7:0]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done_o[sel] !== 1'b0 || busy_o[sel] !== 1'b0) begin
         errors++;
         $display("FAIL %s done_width sel=%0d: done=%b busy=%b, required done=0 busy=0",
                  tag, sel, done_o[sel], busy_o[sel]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < int'(NDUT); s++) begin
         checks++;
         if (busy_o[s] !== 1'b0 || done_o[s] !== 1'b0 || sum_o[s] !== 8'h00 || cout_o[s] !== 1'b0) begin
            errors++;
            $display("FAIL reset sel=%0d: busy=%b done=%b sum=%h cout=%b, required all zero",
                     s, busy_o[s], done_o[s], sum_o[s], cout_o[s]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1_d1");
      run_op(2, 8'h3C, 8'h55, 1'b1, 1'b0, "3c_plus_55_d4");
      run_op(3, 8'hFF, 8'hFF, 1'b1, 1'b0, "max_n1");
      run_op(3, 8'h00, 8'h00, 1'b0, 1'b0, "zero_n1");
      run_op(1, 8'hFF, 8'h00, 1'b1, 1'b0, "carry_ripple_d2");
      run_op(1, 8'h80, 8'h80, 1'b0, 1'b0, "msb_carry_d2");
   endtask

   task automatic test_random();
      for (int s = 0; s < int'(NDUT); s++) begin
         for (int i = 0; i < 60; i++) begin
            run_op(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random");
         end
      end
   endtask

   // start re-pulsed mid-BUSY must neither resample nor add a done pulse
   task automatic test_start_ignored();
      int         pulses;
      logic [7:0] got_sum;
      logic       got_cout;
      pulses   = 0;
      got_sum  = 8'h00;
      got_cout = 1'b0;
      @(negedge clk);
      start_d[1] = 1'b1; a_d[1] = 8'h10; b_d[1] = 8'h20; cin_d[1] = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d[1] = 1'b0;
`endif
      @(posedge clk);
      #1;
      start_d[1] = 1'b0;
      @(posedge clk);
      #1;
      start_d[1] = 1'b1; a_d[1] = 8'h00; b_d[1] = 8'h00;
      @(posedge clk);
      #1;
      start_d[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done_o[1] === 1'b1) begin
            pulses++;
            got_sum  = sum_o[1];
            got_cout = cout_o[1];
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL start_ignored pulses: got %0d, required 1", pulses);
      end
      checks++;
      if (got_sum !== 8'h30 || got_cout !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored result: sum=%h cout=%b, required sum=30 cout=0", got_sum, got_cout);
      end
   endtask

   // rst on the 3rd BUSY cycle aborts silently, then a new op still works
   task automatic test_reset_abort();
      int pulses;
      pulses = 0;
      @(negedge clk);
      start_d[1] = 1'b1; a_d[1] = 8'h11; b_d[1] = 8'h22; cin_d[1] = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d[1] = 1'b0;
`endif
      @(posedge clk);
      #1;
      start_d[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (busy_o[1] !== 1'b0 || done_o[1] !== 1'b0 || sum_o[1] !== 8'h00 || cout_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort state: busy=%b done=%b sum=%h cout=%b, required all zero",
                  busy_o[1], done_o[1], sum_o[1], cout_o[1]);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done_o[1] === 1'b1 || busy_o[1] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_abort activity: got %0d busy/done cycles, required 0", pulses);
      end
      run_op(1, 8'h11, 8'h22, 1'b1, 1'b0, "after_abort");
   endtask

   // start held through DONE: next op accepted at once, done pulses N+1 apart
   task automatic test_back_to_back();
      int n;
      n = n_of(1);
      @(negedge clk);
      start_d[1] = 1'b1; a_d[1] = 8'h40; b_d[1] = 8'h05; cin_d[1] = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d[1] = 1'b0;
`endif
      @(posedge clk);
      #1;
      a_d[1] = 8'h01; b_d[1] = 8'h01; cin_d[1] = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      checks++;
      if (done_o[1] !== 1'b1 || {cout_o[1], sum_o[1]} !== 9'h045) begin
         errors++;
         $display("FAIL b2b first: done=%b cout=%b sum=%h, required done=1 cout=0 sum=45",
                  done_o[1], cout_o[1], sum_o[1]);
      end
      @(posedge clk);
      #1;
      start_d[1] = 1'b0;
      checks++;
      if (busy_o[1] !== 1'b1 || done_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b accept: busy=%b done=%b, required busy=1 done=0", busy_o[1], done_o[1]);
      end
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (i < n) begin
            checks++;
            if (done_o[1] !== 1'b0) begin
               errors++;
               $display("FAIL b2b early_done cyc=%0d: done=%b, required 0", i, done_o[1]);
            end
         end
      end
      checks++;
      if (done_o[1] !== 1'b1 || {cout_o[1], sum_o[1]} !== 9'h002) begin
         errors++;
         $display("FAIL b2b second: done=%b cout=%b sum=%h, required done=1 cout=0 sum=02",
                  done_o[1], cout_o[1], sum_o[1]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b idle: done=%b busy=%b, required 0 0", done_o[1], busy_o[1]);
      end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, "sub_borrow");
      run_op(1, 8'h07, 8'h05, 1'b1, 1'b1, "sub_no_borrow");
      run_op(3, 8'h00, 8'h00, 1'b0, 1'b1, "sub_zero_n1");
      for (int s = 0; s < int'(NDUT); s++) begin
         for (int i = 0; i < 20; i++) begin
            run_op(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "sub_random");
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      for (int s = 0; s < int'(NDUT); s++) begin
         start_d[s] = 1'b0;
         a_d[s]     = 8'h00;
         b_d[s]     = 8'h00;
         cin_d[s]   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_d[s]   = 1'b0;
`endif
      end
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
